// File: rtl/conv2d_stream_feeder.sv
// Transmit side of the conv2D PE input interface: fetches a weight kernel and
// then a feature map from a memory read port, and rebroadcasts the returned
// words in order as two valid-qualified streams.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; job parameters captured on start
// S_REQ   | issuing reads, bounded by MAX_OUTSTANDING in flight
// S_DRAIN | all reads issued; waiting for the remaining responses
// S_DONE  | single-cycle completion pulse
module conv2d_stream_feeder #(
   parameter int AWIDTH          = 32,
   parameter int DWIDTH          = 32,
   parameter int WT_DIM          = 3,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AWIDTH-1:0] wt_base_addr,
   input  logic [AWIDTH-1:0] fm_base_addr,
   input  logic [DWIDTH-1:0] fm_dim,
   output logic              idle,
   output logic              done,
   output logic [AWIDTH-1:0] req_addr,
   output logic              req_valid,
   input  logic              req_ready,
   input  logic [DWIDTH-1:0] resp_data,
   input  logic              resp_valid,
   output logic [DWIDTH-1:0] pe_weight_data_o,
   output logic              pe_weight_data_valid,
   output logic [DWIDTH-1:0] pe_fm_data_o,
   output logic              pe_fm_data_valid
);
   localparam int WT_SIZE = WT_DIM * WT_DIM;
   // One extra bit so WT_SIZE + FM_SIZE never wraps even with a full-width map.
   localparam int CW = DWIDTH + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] WT_SIZE_C = CW'(WT_SIZE);
   localparam logic [OW-1:0] MAX_OS    = OW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [AWIDTH-1:0] wt_base, fm_base;
   logic [DWIDTH-1:0] fm_size;
   logic [CW-1:0]     req_cnt, resp_cnt, total;
   logic [OW-1:0]     outstanding;
   logic              fire, accept, last_req;
   logic [CW-1:0]     word_idx;
   logic [AWIDTH-1:0] word_base;

   assign total     = WT_SIZE_C + {1'b0, fm_size};
   assign req_valid = (state == S_REQ) && (outstanding < MAX_OS);
   assign fire      = req_valid && req_ready;
   assign last_req  = (req_cnt == total - CW'(1));
   // Responses outside REQ/DRAIN, or with nothing in flight, are protocol noise.
   assign accept    = resp_valid && (outstanding != '0) &&
                      ((state == S_REQ) || (state == S_DRAIN));

   // Request address: kernel words first, then map words, 4-byte stride.
   always_comb begin
      if (req_cnt < WT_SIZE_C) begin
         word_idx  = req_cnt;
         word_base = wt_base;
      end else begin
         word_idx  = req_cnt - WT_SIZE_C;
         word_base = fm_base;
      end
      req_addr = word_base + (AWIDTH'(word_idx) << 2);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and status outputs.
   always_comb begin
      state_nxt = state;
      idle      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            idle = 1'b1;
            if (start) state_nxt = S_REQ;
         end
         S_REQ: begin
            if (fire && last_req) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if ((resp_cnt == total) && (outstanding == '0)) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Job parameters and request/response bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wt_base     <= '0;
         fm_base     <= '0;
         fm_size     <= '0;
         req_cnt     <= '0;
         resp_cnt    <= '0;
         outstanding <= '0;
      end else if (state == S_IDLE) begin
         if (start) begin
            wt_base <= wt_base_addr;
            fm_base <= fm_base_addr;
            fm_size <= fm_dim * fm_dim;
         end
         req_cnt     <= '0;
         resp_cnt    <= '0;
         outstanding <= '0;
      end else begin
         if (fire)   req_cnt  <= req_cnt + CW'(1);
         if (accept) resp_cnt <= resp_cnt + CW'(1);
         if (fire && !accept)      outstanding <= outstanding + OW'(1);
         else if (!fire && accept) outstanding <= outstanding - OW'(1);
      end
   end

   // Registered stream outputs; the first WT_SIZE responses are weights.
   always_ff @(posedge clk) begin
      if (rst) begin
         pe_weight_data_o     <= '0;
         pe_weight_data_valid <= 1'b0;
         pe_fm_data_o         <= '0;
         pe_fm_data_valid     <= 1'b0;
      end else begin
         pe_weight_data_valid <= 1'b0;
         pe_fm_data_valid     <= 1'b0;
         if (accept) begin
            if (resp_cnt < WT_SIZE_C) begin
               pe_weight_data_o     <= resp_data;
               pe_weight_data_valid <= 1'b1;
            end else begin
               pe_fm_data_o     <= resp_data;
               pe_fm_data_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv2d_stream_feeder.sv
// Self-checking bench: a fixed-latency in-order memory model feeds the DUT,
// expected words are queued at request time and compared when they emerge.
module tb_conv2d_stream_feeder;
   localparam int MAX_OS = 4;
   localparam int WT_SZ  = 9;
   localparam int BUDGET = 2000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] wt_base_addr = '0;
   logic [31:0] fm_base_addr = '0;
   logic [31:0] fm_dim = '0;
   logic        idle, done;
   logic [31:0] req_addr;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [31:0] resp_data = '0;
   logic        resp_valid = 1'b0;
   logic [31:0] pe_weight_data_o, pe_fm_data_o;
   logic        pe_weight_data_valid, pe_fm_data_valid;

   conv2d_stream_feeder #(
      .AWIDTH(32), .DWIDTH(32), .WT_DIM(3), .MAX_OUTSTANDING(MAX_OS)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .wt_base_addr(wt_base_addr), .fm_base_addr(fm_base_addr), .fm_dim(fm_dim),
      .idle(idle), .done(done),
      .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
      .resp_data(resp_data), .resp_valid(resp_valid),
      .pe_weight_data_o(pe_weight_data_o), .pe_weight_data_valid(pe_weight_data_valid),
      .pe_fm_data_o(pe_fm_data_o), .pe_fm_data_valid(pe_fm_data_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] wt_base;
      logic [31:0] fm_base;
      int          dim;
      int          lat;
      bit          tog;
      int          restart;
      bit          chk_peak;
      bit          chk_adj;
   } row_t;

   typedef struct { int due; logic [31:0] data; } mem_t;
   typedef struct { bit is_fm; logic [31:0] data; } exp_t;

   row_t        rows[6];
   mem_t        mem_q[$];
   exp_t        exp_q[$];
   int          n_cmp = 0, n_bad = 0;
   int          cyc, lat, cur_restart, fires, resps, peak;
   int          wt_seen, fm_seen, done_cnt, last_valid_cyc, last_wt_cyc, first_fm_cyc;
   bit          tog_mode, prev_stall, both_seen;
   logic [31:0] prev_addr, e_wt_base, e_fm_base, last_wt, last_fm;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] exp_addr(input int i);
      if (i < WT_SZ) return e_wt_base + 32'(4 * i);
      return e_fm_base + 32'(4 * (i - WT_SZ));
   endfunction

   task automatic clear_run();
      cyc = 0; fires = 0; resps = 0; peak = 0; prev_stall = 0; both_seen = 0;
      wt_seen = 0; fm_seen = 0; done_cnt = 0; cur_restart = 0;
      last_valid_cyc = -100; last_wt_cyc = -100; first_fm_cyc = -1;
      mem_q.delete(); exp_q.delete();
   endtask

   // One clock: sample outputs, then drive memory inputs for the next edge.
   task automatic step();
      exp_t e;
      mem_t m;
      logic [31:0] ea;
      @(negedge clk);
      cyc++;
      if (pe_weight_data_valid && pe_fm_data_valid) both_seen = 1;
      if (pe_weight_data_valid || pe_fm_data_valid) begin
         if (exp_q.size() == 0) check("unexpected_output", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("stream_sel", pe_fm_data_valid, e.is_fm);
            check("word", pe_fm_data_valid ? pe_fm_data_o : pe_weight_data_o, e.data);
         end
         last_valid_cyc = cyc;
         if (pe_weight_data_valid) begin wt_seen++; last_wt_cyc = cyc; end
         else begin fm_seen++; if (first_fm_cyc < 0) first_fm_cyc = cyc; end
      end
      if (!pe_weight_data_valid) check("wt_hold", pe_weight_data_o, last_wt);
      else last_wt = pe_weight_data_o;
      if (!pe_fm_data_valid) check("fm_hold", pe_fm_data_o, last_fm);
      else last_fm = pe_fm_data_o;
      if (done) begin
         done_cnt++;
         check("done_timing", cyc, last_valid_cyc + 1);
      end

      start = 1'b0;
      if (cur_restart != 0 && cyc == cur_restart) begin
         start = 1'b1; wt_base_addr = 32'hAAA0; fm_base_addr = 32'hBBB0; fm_dim = 7;
      end
      req_ready = tog_mode ? ((cyc % 2) != 0) : 1'b1;
      resp_valid = 1'b0;
      resp_data = 32'hDEAD_BEEF;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         m = mem_q.pop_front();
         resp_valid = 1'b1;
         resp_data = m.data;
         resps++;
      end
      if (prev_stall) begin
         check("hold_req_valid", req_valid, 1);
         check("hold_req_addr", req_addr, prev_addr);
      end
      prev_stall = req_valid && !req_ready;
      prev_addr = req_addr;
      if (req_valid && req_ready) begin
         ea = exp_addr(fires);
         check("req_addr", req_addr, ea);
         m.due = cyc + lat; m.data = mem_word(req_addr);
         mem_q.push_back(m);
         e.is_fm = (fires >= WT_SZ); e.data = mem_word(ea);
         exp_q.push_back(e);
         fires++;
      end
      if (fires - resps > peak) peak = fires - resps;
   endtask

   task automatic run_transfer(input row_t r);
      clear_run();
      e_wt_base = r.wt_base; e_fm_base = r.fm_base;
      lat = r.lat; tog_mode = r.tog; cur_restart = r.restart;
      wt_base_addr = r.wt_base; fm_base_addr = r.fm_base; fm_dim = r.dim;
      start = 1'b1;
      do step(); while (!(done_cnt != 0 && idle) && cyc < BUDGET);
      check("timeout", cyc < BUDGET, 1);
      repeat (3) step();
      check("done_once", done_cnt, 1);
      check("req_count", fires, WT_SZ + r.dim * r.dim);
      check("wt_count", wt_seen, WT_SZ);
      check("fm_count", fm_seen, r.dim * r.dim);
      check("sb_empty", exp_q.size(), 0);
      check("no_overlap", both_seen, 0);
      check("peak_le_max", peak <= MAX_OS, 1);
      if (r.chk_peak) check("peak_eq_max", peak, MAX_OS);
      if (r.chk_adj) check("wt_fm_adjacent", first_fm_cyc, last_wt_cyc + 1);
      check("idle_end", idle, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rows[0] = '{32'h100,      32'h200,      4, 1, 1'b0, 0, 1'b0, 1'b1};
      rows[1] = '{32'h100,      32'h200,      4, 5, 1'b1, 0, 1'b0, 1'b0};
      rows[2] = '{32'h300,      32'h340,      0, 2, 1'b0, 0, 1'b0, 1'b0};
      rows[3] = '{32'h100,      32'h200,      4, 3, 1'b0, 6, 1'b0, 1'b0};
      rows[4] = '{32'h1000,     32'h2000,     3, 5, 1'b0, 0, 1'b1, 1'b0};
      rows[5] = '{32'hFFFF_FFF8, 32'hFFFF_FFF0, 2, 2, 1'b1, 0, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      check("rst_idle", idle, 1);
      check("rst_done", done, 0);
      check("rst_req_valid", req_valid, 0);
      check("rst_wt_valid", pe_weight_data_valid, 0);
      check("rst_fm_valid", pe_fm_data_valid, 0);
      check("rst_wt_data", pe_weight_data_o, 0);
      check("rst_fm_data", pe_fm_data_o, 0);
      rst = 1'b0;
      last_wt = '0; last_fm = '0;

      for (int i = 0; i < 6; i++) run_transfer(rows[i]);

      // Reset in the middle of the kernel fetch, with reads still in flight.
      clear_run();
      e_wt_base = 32'h400; e_fm_base = 32'h800; lat = 3; tog_mode = 0;
      wt_base_addr = 32'h400; fm_base_addr = 32'h800; fm_dim = 5; start = 1'b1;
      do step(); while (wt_seen < 5 && cyc < BUDGET);
      check("rst_mid_reached", wt_seen, 5);
      check("rst_mid_outstanding", fires - resps, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_idle", idle, 1);
      check("rst_mid_req_valid", req_valid, 0);
      check("rst_mid_wt_valid", pe_weight_data_valid, 0);
      check("rst_mid_fm_valid", pe_fm_data_valid, 0);
      check("rst_mid_done", done, 0);
      last_wt = '0; last_fm = '0;
      for (int i = 0; i < 3; i++) begin
         resp_valid = 1'b1;
         resp_data = 32'h1234_0000 + 32'(i);
         @(negedge clk);
         check("late_resp_wt_valid", pe_weight_data_valid, 0);
         check("late_resp_fm_valid", pe_fm_data_valid, 0);
      end
      resp_valid = 1'b0;
      @(negedge clk);
      check("late_resp_wt_valid_end", pe_weight_data_valid, 0);
      check("late_resp_fm_valid_end", pe_fm_data_valid, 0);
      check("late_resp_idle", idle, 1);
      run_transfer(rows[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
